uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmit port.
// Each accepted byte becomes one write pulse, then the FSM tracks txrdy (drop, then recover) before the next grant.
module uart_tx_arbiter #(
  parameter logic [15:0] TX_PORT      = 16'h0000,
  parameter int unsigned DROP_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  data0,
  input  logic        req1,
  input  logic [7:0]  data1,
  input  logic        txrdy,
  output logic        write_strobe,
  output logic [15:0] port_id,
  output logic [7:0]  out_port,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        err,
  output logic [15:0] tx_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DROP, WAIT_RDY} state_t;

  localparam logic [3:0] TIMER_LAST = 4'(DROP_TIMEOUT - 1);

  state_t      state;
  logic [3:0]  timer;
  logic        last;       // requester granted most recently (1 = requester 1)
  logic [7:0]  held;
  logic [15:0] count_q;
  logic        pick;

  // A tie goes to whichever requester was not served last.
  assign pick     = (req0 && req1) ? ~last : req1;
  assign tx_count = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= 4'd0;
      last         <= 1'b1;
      held         <= 8'h00;
      count_q      <= 16'h0000;
      write_strobe <= 1'b0;
      port_id      <= 16'h0000;
      out_port     <= 8'h00;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the state that owns them; all state uses <= so every branch reads pre-edge values.
      write_strobe <= 1'b0;
      port_id      <= 16'h0000;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      err          <= 1'b0;

      unique case (state)
        IDLE: begin
          if (txrdy && (req0 || req1)) begin
            last  <= pick;
            held  <= pick ? data1 : data0;
            state <= ISSUE;
            busy  <= 1'b1;
          end
        end

        ISSUE: begin
          write_strobe <= 1'b1;
          port_id      <= TX_PORT;
          out_port     <= held;
          gnt0         <= ~last;
          gnt1         <= last;
          count_q      <= count_q + 16'd1;
          timer        <= 4'd0;
          state        <= WAIT_DROP;
        end

        WAIT_DROP: begin
          if (!txrdy) begin
            state <= WAIT_RDY;
          end else if (timer == TIMER_LAST) begin
            err   <= 1'b1;
            timer <= 4'd0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 4'd1;
          end
        end

        WAIT_RDY: begin
          if (txrdy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
